// File: rtl/ble_aa_deserializer.sv
// Hunts the serial stream for the BLE access address, then deserialises the
// two-byte PDU header and LEN payload bytes into a pulse-qualified byte stream.
module ble_aa_deserializer #(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter int unsigned MAX_LEN     = 37
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       serial_i,
  input  logic       valid_i,
  input  logic [6:0] channel_i,
  input  logic [7:0] rssi_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       sop_o,
  output logic       eop_o,
  output logic       err_o,
  output logic [6:0] channel_o,
  output logic [7:0] rssi_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  localparam logic [6:0] MaxLen = 7'(MAX_LEN);

  state_t      state_q;
  // Only the 31 (resp. 7) previous bits are stored; the incoming bit completes the word.
  logic [30:0] sr_q;
  logic [31:0] sr_d;
  logic [5:0]  fill_q;
  logic [6:0]  byte_q;
  logic [7:0]  byte_d;
  logic [5:0]  len_d;
  logic [2:0]  bitcnt_q;
  logic        hdr_idx_q;
  logic [5:0]  remain_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        sop_q;
  logic        eop_q;
  logic        err_q;
  logic [6:0]  channel_q;
  logic [7:0]  rssi_q;

  assign sr_d   = {serial_i, sr_q};
  assign byte_d = {serial_i, byte_q};
  assign len_d  = byte_d[5:0];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= HUNT;
      sr_q      <= '0;
      fill_q    <= '0;
      byte_q    <= '0;
      bitcnt_q  <= '0;
      hdr_idx_q <= 1'b0;
      remain_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
      channel_q <= '0;
      rssi_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      if (valid_i) begin
        case (state_q)
          HUNT: begin
            if (fill_q >= 6'd31 && sr_d == ACCESS_ADDR) begin
              // sr/fill are frozen outside HUNT, so clearing here equals clearing on re-entry
              sr_q      <= '0;
              fill_q    <= '0;
              channel_q <= channel_i;
              rssi_q    <= rssi_i;
              bitcnt_q  <= '0;
              hdr_idx_q <= 1'b0;
              state_q   <= HDR;
            end else begin
              sr_q <= sr_d[31:1];
              if (fill_q != 6'd32) fill_q <= fill_q + 6'd1;
            end
          end
          HDR, PAYLOAD: begin
            if (channel_i != channel_q) begin
              err_q   <= 1'b1;
              state_q <= HUNT;
            end else begin
              byte_q   <= byte_d[7:1];
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                if (state_q == HDR && !hdr_idx_q) begin
                  data_q    <= byte_d;
                  valid_q   <= 1'b1;
                  sop_q     <= 1'b1;
                  hdr_idx_q <= 1'b1;
                end else if (state_q == HDR) begin
                  if ({1'b0, len_d} > MaxLen) begin
                    err_q   <= 1'b1;
                    state_q <= HUNT;
                  end else begin
                    data_q   <= byte_d;
                    valid_q  <= 1'b1;
                    remain_q <= len_d;
                    if (len_d == 6'd0) begin
                      eop_q   <= 1'b1;
                      state_q <= HUNT;
                    end else begin
                      state_q <= PAYLOAD;
                    end
                  end
                end else begin
                  data_q   <= byte_d;
                  valid_q  <= 1'b1;
                  remain_q <= remain_q - 6'd1;
                  if (remain_q == 6'd1) begin
                    eop_q   <= 1'b1;
                    state_q <= HUNT;
                  end
                end
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign sop_o     = sop_q;
  assign eop_o     = eop_q;
  assign err_o     = err_q;
  assign channel_o = channel_q;
  assign rssi_o    = rssi_q;
  assign busy_o    = (state_q != HUNT);

endmodule

// File: tb/tb_ble_aa_deserializer.sv
// Bench for ble_aa_deserializer: directed packets plus randomized traffic, every
// cycle compared against a queue-based packet model.
module tb_ble_aa_deserializer;

  localparam logic [31:0] AA   = 32'h8E89BED6;
  localparam int          MAXL = 37;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       serial;
  logic       vin;
  logic [6:0] ch_in;
  logic [7:0] rssi_in;
  logic [7:0] data_o;
  logic       valid_o, sop_o, eop_o, err_o, busy_o;
  logic [6:0] channel_o;
  logic [7:0] rssi_o;

  always #5 clk = ~clk;

  ble_aa_deserializer #(.ACCESS_ADDR(AA), .MAX_LEN(MAXL)) dut (
    .clk_i(clk), .rst_i(rst_n), .serial_i(serial), .valid_i(vin),
    .channel_i(ch_in), .rssi_i(rssi_in), .data_o(data_o), .valid_o(valid_o),
    .sop_o(sop_o), .eop_o(eop_o), .err_o(err_o), .channel_o(channel_o),
    .rssi_o(rssi_o), .busy_o(busy_o)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model state: bit queues since HUNT entry / since byte start.
  bit   hq[$];
  bit   pq[$];
  int   pkt[$];
  bit   in_pkt;
  logic [7:0] e_data;
  logic       e_valid, e_sop, e_eop, e_err, e_busy;
  logic [6:0] e_ch;
  logic [7:0] e_rssi;

  logic [6:0] ch;
  logic [7:0] rs;
  int n_valid, n_err, n_eop;
  logic [7:0] sop_byte, eop_byte;

  task automatic leave_pkt();
    in_pkt = 1'b0;
    hq.delete();
    pq.delete();
  endtask

  task automatic model(input logic v, input logic b, input logic rn,
                       input logic [6:0] c, input logic [7:0] r);
    logic [31:0] w;
    int val, n, plen;
    e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_err = 1'b0;
    if (!rn) begin
      e_data = '0; e_ch = '0; e_rssi = '0;
      leave_pkt();
    end else if (v) begin
      if (!in_pkt) begin
        hq.push_back(b);
        if (hq.size() > 32) void'(hq.pop_front());
        if (hq.size() == 32) begin
          for (int i = 0; i < 32; i++) w[i] = hq[i];
          if (w == AA) begin
            in_pkt = 1'b1;
            e_ch = c;
            e_rssi = r;
            hq.delete(); pq.delete(); pkt.delete();
          end
        end
      end else if (c != e_ch) begin
        e_err = 1'b1;
        leave_pkt();
      end else begin
        pq.push_back(b);
        if (pq.size() == 8) begin
          val = 0;
          for (int i = 0; i < 8; i++) val += int'(pq[i]) << i;
          pq.delete();
          n = pkt.size();
          pkt.push_back(val);
          plen = (n >= 1) ? (pkt[1] % 64) : -1;
          if (n == 1 && plen > MAXL) begin
            e_err = 1'b1;
            leave_pkt();
          end else begin
            e_valid = 1'b1;
            e_data = val[7:0];
            e_sop = (n == 0);
            if (n >= 1 && n == 1 + plen) begin
              e_eop = 1'b1;
              leave_pkt();
            end
          end
        end
      end
    end
    e_busy = in_pkt;
  endtask

  task automatic step(input logic v, input logic b, input logic rn);
    vin = v; serial = b; rst_n = rn; ch_in = ch; rssi_in = rs;
    @(posedge clk);
    model(v, b, rn, ch, rs);
    #1;
    compared++;
    assert ({data_o, valid_o, sop_o, eop_o, err_o, channel_o, rssi_o, busy_o} ===
            {e_data, e_valid, e_sop, e_eop, e_err, e_ch, e_rssi, e_busy})
    else begin
      mismatched++;
      $error("FAIL outs t=%0t obs d=%h v=%b s=%b e=%b x=%b ch=%0d r=%h b=%b exp d=%h v=%b s=%b e=%b x=%b ch=%0d r=%h b=%b",
             $time, data_o, valid_o, sop_o, eop_o, err_o, channel_o, rssi_o, busy_o,
             e_data, e_valid, e_sop, e_eop, e_err, e_ch, e_rssi, e_busy);
    end
    if (valid_o) n_valid++;
    if (err_o) n_err++;
    if (eop_o) begin n_eop++; eop_byte = data_o; end
    if (sop_o) sop_byte = data_o;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_valid = 0; n_err = 0; n_eop = 0; sop_byte = 'x; eop_byte = 'x;
  endtask

  task automatic send_bit(input logic b, input int unsigned gap);
    for (int unsigned i = 0; i < gap; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    step(1'b1, b, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v, input int unsigned gap);
    for (int unsigned i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic send_aa(input int unsigned gap);
    logic [31:0] a;
    a = AA;
    for (int unsigned i = 0; i < 32; i++) send_bit(a[i], gap);
  endtask

  task automatic send_std(input int unsigned gap);
    send_aa(gap);
    send_byte(8'h40, gap);
    send_byte(8'h06, gap);
    for (int unsigned i = 1; i <= 6; i++) send_byte(8'(i), gap);
  endtask

  initial begin
    logic [7:0] bytes[$];
    int unsigned gap, len, abort_at, bitidx;
    ch = 7'd37; rs = 8'hA5;
    e_data = '0; e_ch = '0; e_rssi = '0; in_pkt = 1'b0;
    clr_counts();
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("reset_outs", {4'd0, data_o, valid_o, sop_o, eop_o, err_o, channel_o, rssi_o, busy_o}, 32'd0);

    // Basic packet, continuous valid
    clr_counts();
    send_std(0);
    chk("t1_nvalid", n_valid, 8);
    chk("t1_sop_byte", sop_byte, 8'h40);
    chk("t1_eop_byte", eop_byte, 8'h06);
    chk("t1_channel", channel_o, 37);
    chk("t1_rssi", rssi_o, 8'hA5);
    chk("t1_busy", busy_o, 0);

    // Same packet, one bit every third cycle
    clr_counts();
    send_std(2);
    chk("t2_nvalid", n_valid, 8);
    chk("t2_eop_byte", eop_byte, 8'h06);

    // Zero-length packet
    clr_counts();
    send_aa(0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    chk("t3_nvalid", n_valid, 2);
    chk("t3_eop_byte", eop_byte, 8'h00);
    chk("t3_busy", busy_o, 0);

    // Oversize length aborts, then a good packet
    clr_counts();
    send_aa(0); send_byte(8'h02, 0); send_byte(8'h28, 0);
    chk("t4_nvalid", n_valid, 1);
    chk("t4_nerr", n_err, 1);
    chk("t4_neop", n_eop, 0);
    clr_counts();
    send_std(1);
    chk("t4b_nvalid", n_valid, 8);

    // Channel change during payload byte 3, then AA on the new channel
    clr_counts();
    send_aa(0); send_byte(8'h40, 0); send_byte(8'h06, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    for (int unsigned i = 0; i < 3; i++) send_bit(1'b1, 0);
    ch = 7'd38;
    send_bit(1'b0, 0);
    chk("t5_nerr", n_err, 1);
    chk("t5_nvalid", n_valid, 5);
    chk("t5_busy", busy_o, 0);
    rs = 8'h3C;
    send_aa(0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    chk("t5_channel", channel_o, 38);
    chk("t5_rssi", rssi_o, 8'h3C);

    // Reset mid-payload, then a near-miss AA
    ch = 7'd37;
    send_aa(0); send_byte(8'h40, 0); send_byte(8'h06, 0); send_byte(8'h11, 0);
    clr_counts();
    step(1'b1, 1'b1, 1'b0);
    chk("t6_reset_outs", {4'd0, data_o, valid_o, sop_o, eop_o, err_o, channel_o, rssi_o, busy_o}, 32'd0);
    begin
      logic [31:0] a;
      a = AA;
      for (int unsigned i = 0; i < 31; i++) send_bit(a[i], 0);
      send_bit(~a[31], 0);
    end
    chk("t6_nomatch_busy", busy_o, 0);
    chk("t6_eop_err", n_eop + n_err, 0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      gap = $urandom_range(0, 2);
      ch = 7'($urandom_range(0, 39));
      rs = 8'($urandom);
      for (int unsigned i = 0; i < $urandom_range(0, 12); i++) send_bit(1'($urandom), gap);
      len = $urandom_range(0, 45);
      bytes.delete();
      bytes.push_back(8'($urandom));
      bytes.push_back({2'($urandom), 6'(len)});
      for (int unsigned i = 0; i < len; i++) bytes.push_back(8'($urandom));
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 8 * (len + 2) - 1) : 32'hFFFF_FFFF;
      send_aa(gap);
      bitidx = 0;
      foreach (bytes[j]) begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (bitidx == abort_at) ch = ch + 7'd1;
          send_bit(bytes[j][i], gap);
          bitidx++;
        end
      end
      if ($urandom_range(0, 9) == 0) step(1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ble_aa_deserializer.md
# ble_aa_deserializer

Front-end stage of the BLE sniffer datapath, directly downstream of the radio-side serial input (`serial_i`/`valid_i`/`channel_i`/`rssi_i`) and upstream of the packet buffering and USB framing logic. It hunts the serial bit stream for the advertising access address and deserialises the PDU header and payload into bytes. It emits those bytes as a pulse-qualified byte stream with start/end/abort markers, tagged with the channel and RSSI latched at the access-address match.

## Interface
Parameters:
- `ACCESS_ADDR`, 32'h8E89BED6: access address to match, in natural bit order.
- `MAX_LEN`, 37: largest accepted payload length, in bytes.

Ports:
- `clk_i`  in  1  single clock; every register is updated on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `serial_i`  in  1  serial data bit, LSB-first over air; sampled only when `valid_i`=1.
- `valid_i`  in  1  qualifies `serial_i`, at most one bit per cycle.
- `channel_i`  in  7  current RF channel.
- `rssi_i`  in  8  current RSSI.
- `data_o`  out  8  deserialised byte.
- `valid_o`  out  1  one-cycle pulse; `data_o` is valid.
- `sop_o`  out  1  asserted with `valid_o` on header byte 0.
- `eop_o`  out  1  asserted with `valid_o` on the last byte of the packet.
- `err_o`  out  1  one-cycle pulse; the current packet is aborted and downstream discards the partial packet.
- `channel_o`  out  7  channel latched at the access-address match.
- `rssi_o`  out  8  RSSI latched at the access-address match.
- `busy_o`  out  1  high in HDR or PAYLOAD.

## Operation
- States: HUNT, HDR, PAYLOAD.
- "Bit event" means a cycle with `valid_i`=1. Cycles with `valid_i`=0 change no state, counter or shift register.
- HUNT:
  - Each bit event updates the 32-bit register: `sr <= {serial_i, sr[31:1]}`.
  - A 6-bit fill counter increments on each bit event and saturates at 32.
  - Match condition: bit event with fill ≥ 31 before the update, and `{serial_i, sr[31:1]} == ACCESS_ADDR`.
  - On match: latch `channel_i`→`channel_o` and `rssi_i`→`rssi_o`, clear the byte and bit counters, go to HDR.
- Byte assembly in HDR and PAYLOAD:
  - `byte <= {serial_i, byte[7:1]}` on each bit event.
  - On the 8th bit the completed byte is registered onto `data_o` and `valid_o` pulses.
- HDR, two bytes:
  - Byte 0 is emitted with `sop_o`=1.
  - Byte 1: `LEN = byte1[5:0]`.
    - LEN > MAX_LEN: byte 1 is not emitted; `err_o` pulses; go to HUNT.
    - LEN = 0: byte 1 is emitted with `eop_o`=1; go to HUNT.
    - Otherwise byte 1 is emitted; go to PAYLOAD with the remaining count = LEN.
- PAYLOAD: emits LEN bytes; the last one carries `eop_o`=1, then go to HUNT.
- Channel abort: in HDR or PAYLOAD, a bit event with `channel_i` ≠ `channel_o`:
  - that bit is discarded;
  - `err_o` pulses and no further byte is emitted for the packet;
  - go to HUNT.
- Every entry into HUNT clears `sr` and the fill counter. Bits of a packet are never reused for AA hunting.
- No backpressure; downstream must accept one byte per 8 bit events.
- `channel_o`/`rssi_o` hold their values until the next match.
- `sop_o`, `eop_o` and `err_o` never assert without their defined event. `err_o` and `valid_o` are never high in the same cycle.

## Timing
- Reset (`rst_i`=0 at a rising edge), effective the following cycle:
  - all outputs are 0: `data_o`=0, `valid_o`=0, `sop_o`=0, `eop_o`=0, `err_o`=0, `channel_o`=0, `rssi_o`=0, `busy_o`=0;
  - state is HUNT, `sr`=0, fill=0.
  - Reset mid-packet: no `eop_o` and no `err_o` is produced.
- Match: `busy_o` rises the cycle after the 32nd AA bit is sampled.
- Byte latency: `valid_o` is high exactly one cycle, in the cycle after the 8th bit of the byte is sampled.
- `err_o` (length or channel): asserted the cycle after the offending bit event.
- `busy_o` falls the cycle after the last bit of the packet, i.e. together with the final `valid_o`/`eop_o` or `err_o` pulse.
- A new match may occur at the earliest after 32 further bit events once back in HUNT.

## Test plan
- AA 8E89BED6 on channel 37, `rssi_i`=0xA5, header 0x40,0x06, payload 01..06, `valid_i` always 1 → 8 `valid_o` pulses; `sop_o` on 0x40; `eop_o` on 0x06; `channel_o`=37; `rssi_o`=0xA5; `busy_o` low after the last byte.
- Same packet with `valid_i`=1 only every 3rd cycle and `serial_i` randomised on invalid cycles → identical byte stream; each `valid_o` comes one cycle after the 8th valid bit.
- Header 0x02,0x00 → 2 bytes; `sop_o` on 0x02; `eop_o` on 0x00; return to HUNT.
- Header 0x02,0x28 (LEN=40) → only 0x02 emitted; `err_o` one cycle after the 16th header bit; no `eop_o`; a following valid packet is received correctly.
- `channel_i` 37→38 during payload byte 3 → `err_o` pulse, no more bytes, `busy_o`=0. An AA on 38 afterwards is captured with `channel_o`=38.
- `rst_i` low for one cycle in the middle of the payload → all outputs 0 the next cycle. Feeding only 31 AA bits then 1 wrong bit → no match.
